ws2811_bit_encoder: RTL

- Serialises 24-bit WS2811 pixel words into the single-wire NRZ waveform.
- Sits directly downstream of the free-running tick counter: that counter's one-cycle overflow pulse is this block's time base, one tick per waveform slot.
- Upstream pixel source feeds it over a valid/ready handshake with a frame-end flag.
- Appends the latch/reset low period after each frame.

---
 rtl/ws2811_bit_encoder_if.sv | 21 ++
 rtl/ws2811_bit_encoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ws2811_bit_encoder_if.sv
// rtl/ws2811_bit_encoder_if.sv - pixel valid/ready handshake bundle for the WS2811 encoder
interface ws2811_bit_encoder_if;
    logic [23:0] pixelIN;
    logic        lastPixelIN;
    logic        pixelValidIN;
    logic        pixelReadyOUT;

    modport master (
        output pixelIN,
        output lastPixelIN,
        output pixelValidIN,
        input  pixelReadyOUT
    );

    modport slave (
        input  pixelIN,
        input  lastPixelIN,
        input  pixelValidIN,
        output pixelReadyOUT
    );
endinterface

// File: rtl/ws2811_bit_encoder.sv
// rtl/ws2811_bit_encoder.sv - serialises 24-bit pixels into the WS2811 NRZ waveform plus latch low period
module ws2811_bit_encoder #(
    parameter int T0H_TICKS   = 2,
    parameter int T1H_TICKS   = 5,
    parameter int BIT_TICKS   = 10,
    parameter int LATCH_TICKS = 400
) (
    input  logic                clkIN,
    input  logic                resetIN,
    input  logic                tickIN,
    ws2811_bit_encoder_if.slave pixelBus,
    output logic                dataOUT,
    output logic                busyOUT,
    output logic                frameDoneOUT,
    output logic                underrunOUT
);

    localparam int PHASE_W = $clog2(BIT_TICKS);
    localparam int LATCH_W = $clog2(LATCH_TICKS + 1);

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BIT_TICKS - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] T0H        = PHASE_W'(T0H_TICKS);
    localparam logic [PHASE_W-1:0] T1H        = PHASE_W'(T1H_TICKS);
    localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_TICKS - 1);
    localparam logic [LATCH_W-1:0] LATCH_ONE  = LATCH_W'(1);
    localparam logic [4:0]         BIT_LAST   = 5'd23;
    localparam logic [4:0]         BIT_ONE    = 5'd1;

    // A timing set that cannot produce distinguishable 0/1 bits is rejected at elaboration
    generate
        if (!(T0H_TICKS > 0 && T0H_TICKS < T1H_TICKS && T1H_TICKS < BIT_TICKS)) begin : g_bad_bit_timing
            $error("ws2811_bit_encoder: need 0 < T0H_TICKS < T1H_TICKS < BIT_TICKS");
        end
        if (LATCH_TICKS < 1) begin : g_bad_latch_timing
            $error("ws2811_bit_encoder: LATCH_TICKS must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } encState;

    encState              stateQ, stateNext;
    logic [23:0]          holdPixel;
    logic                 holdLast;
    logic                 holdValid;
    logic [23:0]          shifterQ, shifterNext;
    logic                 curLastQ, curLastNext;
    logic [4:0]           bitQ, bitNext;
    logic [PHASE_W-1:0]   phaseQ, phaseNext;
    logic [LATCH_W-1:0]   latchQ, latchNext;
    logic                 dataNext;
    logic                 frameDoneNext;
    logic                 underrunNext;
    logic                 loadShifter;
    logic [PHASE_W-1:0]   highTicks;
    logic [PHASE_W-1:0]   phaseInc;

    assign pixelBus.pixelReadyOUT = !holdValid;

    // Hold register: filled by a handshake, emptied when the shifter takes its contents
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            holdValid <= 1'b0;
            holdPixel <= '0;
            holdLast  <= 1'b0;
        end else if (pixelBus.pixelValidIN && !holdValid) begin
            holdValid <= 1'b1;
            holdPixel <= pixelBus.pixelIN;
            holdLast  <= pixelBus.lastPixelIN;
        end else if (loadShifter) begin
            holdValid <= 1'b0;
        end
    end

    // Encoder state register; everything here only moves on tick edges via the next-state logic
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            stateQ       <= IDLE;
            shifterQ     <= '0;
            curLastQ     <= 1'b0;
            bitQ         <= '0;
            phaseQ       <= '0;
            latchQ       <= '0;
            dataOUT      <= 1'b0;
            busyOUT      <= 1'b0;
            frameDoneOUT <= 1'b0;
            underrunOUT  <= 1'b0;
        end else begin
            stateQ       <= stateNext;
            shifterQ     <= shifterNext;
            curLastQ     <= curLastNext;
            bitQ         <= bitNext;
            phaseQ       <= phaseNext;
            latchQ       <= latchNext;
            dataOUT      <= dataNext;
            busyOUT      <= (stateNext != IDLE);
            frameDoneOUT <= frameDoneNext;
            underrunOUT  <= underrunNext;
        end
    end

    // Next-state and line level: each bit is BIT_TICKS slots, high while the upcoming phase is below Th
    always_comb begin
        stateNext     = stateQ;
        shifterNext   = shifterQ;
        curLastNext   = curLastQ;
        bitNext       = bitQ;
        phaseNext     = phaseQ;
        latchNext     = latchQ;
        dataNext      = dataOUT;
        frameDoneNext = 1'b0;
        underrunNext  = 1'b0;
        loadShifter   = 1'b0;
        highTicks     = shifterQ[23] ? T1H : T0H;
        phaseInc      = phaseQ + PHASE_ONE;

        if (tickIN) begin
            case (stateQ)
                IDLE: begin
                    if (holdValid) begin
                        loadShifter = 1'b1;
                    end
                end
                SHIFT: begin
                    if (phaseQ != PHASE_LAST) begin
                        phaseNext = phaseInc;
                        dataNext  = (phaseInc < highTicks);
                    end else if (bitQ != BIT_LAST) begin
                        shifterNext = {shifterQ[22:0], 1'b0};
                        bitNext     = bitQ + BIT_ONE;
                        phaseNext   = '0;
                        dataNext    = 1'b1;
                    end else if (!curLastQ && holdValid) begin
                        loadShifter = 1'b1;
                    end else begin
                        stateNext    = LATCH;
                        latchNext    = '0;
                        dataNext     = 1'b0;
                        underrunNext = !curLastQ;
                    end
                end
                LATCH: begin
                    dataNext = 1'b0;
                    if (latchQ == LATCH_LAST) begin
                        stateNext     = IDLE;
                        latchNext     = '0;
                        frameDoneNext = 1'b1;
                    end else begin
                        latchNext = latchQ + LATCH_ONE;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    dataNext  = 1'b0;
                end
            endcase

            // A load starts the first high slot of bit 23 on this same edge
            if (loadShifter) begin
                stateNext   = SHIFT;
                shifterNext = holdPixel;
                curLastNext = holdLast;
                bitNext     = '0;
                phaseNext   = '0;
                dataNext    = 1'b1;
            end
        end
    end

endmodule
